// File: rtl/temp_display.sv
// temp_display: sign-magnitude temperature to 4-digit multiplexed 7-segment display.
// A sequential double-dabble engine converts the 8-bit magnitude to three BCD
// digits; results are latched atomically into display registers that a free
// running scanner multiplexes onto a common-anode display (active-low an/seg).
module temp_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] temp_in,
    input  logic       update,
    output logic       busy,
    output logic       valid,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    // Digit code reserved for a blanked digit.
    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_sign;
    logic [7:0]       r_mag;
    logic [11:0]      r_bcd;
    logic [2:0]       r_bit_cnt;
    logic             r_pend;
    logic [8:0]       r_pend_val;
    logic             r_valid;
    logic             r_disp_sign;
    logic [3:0]       r_disp_h;
    logic [3:0]       r_disp_t;
    logic [3:0]       r_disp_o;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_digit;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;

    logic [11:0]      w_bcd_adj;
    logic [11:0]      w_bcd_shift;
    logic [7:0]       w_mag_shift;
    logic [3:0]       w_dig_sel;
    logic [6:0]       w_seg_sel;

    // Add-3 correction on every BCD nibble that would overflow when doubled.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                          (r_bcd[gi*4 +: 4] + 4'd3) :
                                          r_bcd[gi*4 +: 4];
        end
    endgenerate

    assign {w_bcd_shift, w_mag_shift} = {w_bcd_adj, r_mag} << 1;

    // A request is outstanding whenever the engine is active or one is queued.
    assign busy  = (r_state != IDLE) | r_pend;
    assign valid = r_valid;
    assign an    = r_an;
    assign seg   = r_seg;

    // Conversion FSM: capture, eight shift-add-3 steps, then atomic display load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_bcd       <= '0;
            r_bit_cnt   <= '0;
            r_pend      <= 1'b0;
            r_pend_val  <= '0;
            r_valid     <= 1'b0;
            r_disp_sign <= 1'b0;
            r_disp_h    <= DIG_BLANK;
            r_disp_t    <= DIG_BLANK;
            r_disp_o    <= DIG_BLANK;
        end else begin
            case (r_state)
                IDLE: begin
                    if (update) begin
                        r_sign    <= temp_in[8];
                        r_mag     <= temp_in[7:0];
                        r_bcd     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_bcd     <= w_bcd_shift;
                    r_mag     <= w_mag_shift;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= LOAD;
                    end
                    if (update) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= temp_in;
                    end
                end
                LOAD: begin
                    // Leading-zero blanking; a zero magnitude never shows a minus.
                    r_disp_sign <= r_sign && (r_bcd != 12'd0);
                    r_disp_h    <= (r_bcd[11:8] == 4'd0) ? DIG_BLANK : r_bcd[11:8];
                    r_disp_t    <= (r_bcd[11:4] == 8'd0) ? DIG_BLANK : r_bcd[7:4];
                    r_disp_o    <= r_bcd[3:0];
                    r_valid     <= 1'b1;
                    r_bcd       <= '0;
                    r_bit_cnt   <= '0;
                    // An update on this edge is the newest request and wins.
                    if (update) begin
                        r_sign  <= temp_in[8];
                        r_mag   <= temp_in[7:0];
                        r_pend  <= 1'b0;
                        r_state <= CONVERT;
                    end else if (r_pend) begin
                        r_sign  <= r_pend_val[8];
                        r_mag   <= r_pend_val[7:0];
                        r_pend  <= 1'b0;
                        r_state <= CONVERT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scan timer: each digit slot lasts SCAN_DIV cycles, digits rotate 0..3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd0;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_digit    <= r_digit + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    // Select the digit code for the active slot.
    always_comb begin
        w_dig_sel = DIG_BLANK;
        case (r_digit)
            2'd0:    w_dig_sel = r_disp_o;
            2'd1:    w_dig_sel = r_disp_t;
            2'd2:    w_dig_sel = r_disp_h;
            default: w_dig_sel = DIG_BLANK;
        endcase
    end

    // Segment decode, with the sign slot and the pre-first-result state handled.
    always_comb begin
        w_seg_sel = SEG_BLANK;
        if (r_valid) begin
            if (r_digit == 2'd3) begin
                w_seg_sel = r_disp_sign ? SEG_MINUS : SEG_BLANK;
            end else begin
                case (w_dig_sel)
                    4'd0:    w_seg_sel = 7'b1000000;
                    4'd1:    w_seg_sel = 7'b1111001;
                    4'd2:    w_seg_sel = 7'b0100100;
                    4'd3:    w_seg_sel = 7'b0110000;
                    4'd4:    w_seg_sel = 7'b0011001;
                    4'd5:    w_seg_sel = 7'b0010010;
                    4'd6:    w_seg_sel = 7'b0000010;
                    4'd7:    w_seg_sel = 7'b1111000;
                    4'd8:    w_seg_sel = 7'b0000000;
                    4'd9:    w_seg_sel = 7'b0010000;
                    default: w_seg_sel = SEG_BLANK;
                endcase
            end
        end
    end

    // Registered display drive so anode and segments switch together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(4'b0001 << r_digit);
            r_seg <= w_seg_sel;
        end
    end

endmodule

// File: tb/tb_temp_display.sv
// Self-checking bench for temp_display using a decimal-arithmetic display model.
module tb_temp_display;

    localparam int SD = 4;

    logic       clk;
    logic       rst;
    logic [8:0] temp_in;
    logic       update;
    logic       busy;
    logic       valid;
    logic [3:0] an;
    logic [6:0] seg;

    int n_checks;
    int n_pass;
    bit first_done;

    temp_display #(.SCAN_DIV(SD)) dut (
        .clk     (clk),
        .rst     (rst),
        .temp_in (temp_in),
        .update  (update),
        .busy    (busy),
        .valid   (valid),
        .an      (an),
        .seg     (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Seven-segment glyph table for decimal digits (active-low {g..a}).
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected pattern for display position pos (0 = ones .. 3 = sign).
    function automatic logic [6:0] model_seg(input logic [8:0] v, input int pos);
        int mag, h, t, o;
        mag = int'(v[7:0]);
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        case (pos)
            0: return glyph(o);
            1: return (h == 0 && t == 0) ? 7'b1111111 : glyph(t);
            2: return (h == 0) ? 7'b1111111 : glyph(h);
            default: return (v[8] && mag != 0) ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    // Pulse update for one edge (edge k); returns #1 after that edge.
    task automatic pulse_update(input logic [8:0] v);
        temp_in = v;
        update  = 1'b1;
        tick();
        update  = 1'b0;
    endtask

    // Let the scan refresh, then observe one full scan period per digit.
    task automatic check_display(input logic [8:0] v, input string tag);
        logic [6:0] got [4];
        bit seen [4];
        bit bad [4];
        bit an_bad;
        logic [3:0] an_bad_val;
        int zeros, pos;
        for (int i = 0; i < 4; i++) begin
            seen[i] = 0;
            bad[i] = 0;
            got[i] = 7'h7F;
        end
        an_bad = 0;
        an_bad_val = 4'b1111;
        for (int c = 0; c < 4 * SD + 2; c++) tick();
        for (int c = 0; c < 4 * SD; c++) begin
            tick();
            zeros = 0;
            pos = 0;
            for (int b = 0; b < 4; b++) begin
                if (an[b] == 1'b0) begin
                    zeros++;
                    pos = b;
                end
            end
            if (zeros != 1) begin
                an_bad = 1;
                an_bad_val = an;
            end else begin
                seen[pos] = 1;
                if (seg !== model_seg(v, pos)) bad[pos] = 1;
                got[pos] = seg;
            end
        end
        n_checks++;
        if (an_bad) $display("FAIL %s an_onecold: got %b, required exactly one zero bit", tag, an_bad_val);
        else n_pass++;
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (!seen[d] || bad[d])
                $display("FAIL %s digit%0d (v=%h): got %b seen=%0d, required %b", tag, d, v, got[d], seen[d], model_seg(v, d));
            else n_pass++;
        end
        $display("display %s v=%h segs(3..0)=%b %b %b %b", tag, v, got[3], got[2], got[1], got[0]);
    endtask

    // Single conversion from IDLE: busy/valid timing then the displayed result.
    task automatic run_conversion(input logic [8:0] v, input string tag);
        pulse_update(v);                       // edge k
        n_checks++;
        if (busy !== 1'b1) $display("FAIL %s busy_k: got %b, required 1", tag, busy);
        else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            tick();                            // edge k+i
            n_checks++;
            if (busy !== 1'b1) $display("FAIL %s busy_k+%0d: got %b, required 1", tag, i, busy);
            else n_pass++;
        end
        n_checks++;
        if (valid !== first_done) $display("FAIL %s valid_k+8: got %b, required %b", tag, valid, first_done);
        else n_pass++;
        tick();                                // edge k+9
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b1)
            $display("FAIL %s done_k+9: got busy=%b valid=%b, required busy=0 valid=1", tag, busy, valid);
        else n_pass++;
        first_done = 1;
        check_display(v, tag);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (an !== 4'b1111 || seg !== 7'h7F || busy !== 1'b0 || valid !== 1'b0)
                $display("FAIL reset_hold: got an=%b seg=%b busy=%b valid=%b, required 1111 1111111 0 0", an, seg, busy, valid);
            else n_pass++;
        end
        rst = 1'b1;
        for (int i = 0; i < 4 * SD; i++) begin
            logic [3:0] exp_an;
            tick();
            exp_an = ~(4'b0001 << (i / SD));
            n_checks++;
            if (an !== exp_an || seg !== 7'h7F)
                $display("FAIL reset_scan%0d: got an=%b seg=%b, required an=%b seg=1111111", i, an, seg, exp_an);
            else n_pass++;
        end
        $display("reset: scan sequence observed with blank digits");
    endtask

    task automatic test_directed;
        run_conversion(9'h07B, "plus123");
        run_conversion(9'h119, "minus25");
        run_conversion(9'h100, "negzero");
        run_conversion(9'h0FF, "plus255");
        run_conversion(9'h000, "zero");
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            logic [8:0] v;
            v = 9'($urandom_range(0, 511));
            run_conversion(v, "random");
        end
    endtask

    // Two overlapping updates while busy; only the newest is converted next.
    task automatic test_queued;
        pulse_update(9'h00A);                  // edge k
        for (int e = 1; e <= 18; e++) begin
            if (e == 3) begin temp_in = 9'h0C8; update = 1'b1; end
            if (e == 5) begin temp_in = 9'h005; update = 1'b1; end
            tick();
            update = 1'b0;
            n_checks++;
            if (e < 18 && busy !== 1'b1) $display("FAIL queued busy_k+%0d: got %b, required 1", e, busy);
            else if (e == 18 && busy !== 1'b0) $display("FAIL queued busy_k+18: got %b, required 0", busy);
            else n_pass++;
        end
        check_display(9'h005, "queued");
    endtask

    // Update arriving on the LOAD edge chains straight into the next conversion.
    task automatic test_back_to_back;
        logic [8:0] a, b;
        a = 9'($urandom_range(0, 511));
        b = 9'($urandom_range(0, 511));
        pulse_update(a);                       // edge k
        for (int e = 1; e <= 18; e++) begin
            if (e == 9) begin temp_in = b; update = 1'b1; end
            tick();
            update = 1'b0;
            n_checks++;
            if (e < 18 && busy !== 1'b1) $display("FAIL b2b busy_k+%0d: got %b, required 1", e, busy);
            else if (e == 18 && busy !== 1'b0) $display("FAIL b2b busy_k+18: got %b, required 0", busy);
            else n_pass++;
        end
        check_display(b, "b2b");
    endtask

    // Asynchronous reset in the middle of a conversion, then a clean restart.
    task automatic test_reset_mid;
        pulse_update(9'h0FF);                  // edge k
        for (int i = 1; i <= 4; i++) tick();   // edge k+4
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || an !== 4'b1111 || seg !== 7'h7F)
            $display("FAIL midreset_async: got busy=%b valid=%b an=%b seg=%b, required 0 0 1111 1111111", busy, valid, an, seg);
        else n_pass++;
        tick();
        tick();
        rst = 1'b1;
        first_done = 0;
        for (int i = 0; i < 4 * SD; i++) begin
            tick();
            n_checks++;
            if (seg !== 7'h7F || valid !== 1'b0)
                $display("FAIL midreset_blank%0d: got seg=%b valid=%b, required 1111111 0", i, seg, valid);
            else n_pass++;
        end
        run_conversion(9'h12A, "after_reset");
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        first_done = 0;
        rst = 1'b0;
        update = 1'b0;
        temp_in = '0;
        test_reset();
        test_directed();
        test_random();
        test_queued();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, required finish before bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/temp_display.md
# temp_display

Display back end for the temperature averager. It takes the 9-bit sign-magnitude average and the minute strobe from the averaging stage, converts the magnitude to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a 4-digit multiplexed common-anode 7-segment display. Digit 3 shows the sign; digits 2..0 show hundreds, tens and ones.

## Interface
Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (1 kHz digit rate at 50 MHz). Legal range ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- temp_in  in  9  bit 8 is the sign (1 = negative); bits 7:0 are the magnitude, 0..255.
- update  in  1  single-cycle strobe (driven by the averager's minute output) that requests conversion of temp_in.
- busy  out  1  high while a conversion is queued or running.
- valid  out  1  low from reset until the first completed conversion, then held high.
- an  out  4  digit enables, active-low one-hot; an[0] = ones, an[3] = sign.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states: IDLE, CONVERT, LOAD.
- IDLE:
  - When update=1, capture temp_in into src, clear the BCD shift register (12 bits), set bit count = 0, go to CONVERT.
- CONVERT, 8 cycles:
  - Each cycle, add 3 to every BCD nibble ≥5.
  - Then shift {bcd, mag} left by 1.
  - After the 8th shift, go to LOAD.
- LOAD, 1 cycle:
  - Write disp_sign, disp_h, disp_t, disp_o.
  - Set valid=1.
  - Go to IDLE, or to CONVERT if a request is pending.
- Pending request (one deep):
  - update=1 while in CONVERT or LOAD sets pend and captures temp_in into pend_val.
  - A later update before service overwrites pend_val (latest value wins).
  - On leaving LOAD with pend=1: load src from pend_val, clear pend, enter CONVERT.
- Digit rules:
  - Hundreds blank if 0.
  - Tens blank if hundreds and tens are both 0.
  - Ones always shown.
  - Sign digit shows minus (0111111) only when temp_in[8]=1 and magnitude ≠ 0. Negative zero displays as plain 0 with a blank sign.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Scanning:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On wrap, digit index 0→1→2→3→0.
  - an and seg are registered from the digit index and the disp_* registers.
- Before the first conversion (valid=0), all digits are blank.

## Timing
- Reset values: state=IDLE, busy=0, valid=0, pend=0, an=1111, seg=1111111, scan_cnt=0, digit index=0, disp_* = blank.
- Reset during a conversion aborts it immediately. The display returns to blank and valid=0.
- Conversion latency, for update sampled at edge k:
  - busy=1 after edge k.
  - Shifts occur on edges k+1..k+8.
  - LOAD writes the disp_* registers on edge k+9.
  - busy=0 after edge k+9 unless a request is pending.
- The updated digit appears on an/seg one cycle after the next time its digit index is selected (registered output).
- Scan timing:
  - an changes 1 cycle after scan_cnt wraps.
  - Each digit is active for exactly SCAN_DIV cycles.
  - an never has more than one zero bit.
- update coincident with the LOAD edge is treated as pending. The next conversion starts directly, with no IDLE cycle, and busy stays high.
- busy = (state≠IDLE) | pend.
- Scanning runs continuously and is independent of conversion. disp_* change atomically in the LOAD cycle, so a scan never shows a mix of old and new digits.

## Test plan
- Reset: hold rst=0 for 5 cycles, release → an=1111, seg=1111111, busy=0, valid=0. With SCAN_DIV=4, after release an cycles 1110,1101,1011,0111 with every digit blank.
- +123 (temp_in=9'h07B) with update pulse at edge k → busy high for k+1..k+9. Scan then shows ones=0110000, tens=0100100, hundreds=1111001, sign=blank; valid=1.
- -25 (9'h119) → ones=0010010, tens=0100100, hundreds=blank, sign=0111111.
- Zero cases: 9'h100 (negative zero) → ones=1000000, all others blank. 9'h0FF → 2,5,5 with blank sign.
- Queued updates: update with 9'h00A, then 9'h0C8 at k+3, then 9'h005 at k+5 → the first result (10) loads at k+9. The second conversion uses 5 (latest wins), loads at k+18, and busy stays high continuously from k+1 through k+18.
- Reset mid-conversion: assert rst at k+4 of a 9'h0FF conversion → display blank and valid=0. After release, a new update converts cleanly with a 9-cycle latency.
